// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] SCRUB_FIRST = 5'd1;
  localparam logic [REG_ADDR_W-1:0] SCRUB_LAST  = 5'd31;

  typedef enum logic {
    RUN   = 1'b0,
    SCRUB = 1'b1
  } wr_arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester found searching upward
// from (last_grant + 1) mod NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_any
);
  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = PW'((32'(i_last_grant) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any       = 1'b1;
        o_grant_idx = w_idx;
      end
    end
    o_grant[o_grant_idx] = o_any;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port among NUM_REQ
// writeback sources, with register-0 write filtering and a 1..31 zero scrub.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*REG_DATA_W-1:0]  req_data,
  input  logic                           scrub_start,
  input  logic                           err_clear,
  output logic                           write_switch,
  output logic [REG_ADDR_W-1:0]          write_register,
  output logic [REG_DATA_W-1:0]          write_data,
  output logic                           busy,
  output logic                           scrub_done,
  output logic                           zero_write_err
);
  localparam int PW = $clog2(NUM_REQ);

  wr_arb_state_t           r_state;
  wr_arb_state_t           w_next_state;
  logic [REG_ADDR_W-1:0]   r_counter;
  logic [PW-1:0]           r_last_grant;
  logic                    r_write_switch;
  logic [REG_ADDR_W-1:0]   r_write_register;
  logic [REG_DATA_W-1:0]   r_write_data;
  logic                    r_busy;
  logic                    r_scrub_done;
  logic                    r_zero_err;

  logic [NUM_REQ-1:0]      w_grant;
  logic [PW-1:0]           w_grant_idx;
  logic                    w_any;
  logic                    w_arb_en;
  logic                    w_xfer;
  logic [REG_ADDR_W-1:0]   w_sel_addr;
  logic [REG_DATA_W-1:0]   w_sel_data;
  logic                    w_wr_en;
  logic [REG_ADDR_W-1:0]   w_wr_addr;
  logic [REG_DATA_W-1:0]   w_wr_data;
  logic                    w_set_err;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx),
    .o_any        (w_any)
  );

  // A scrub request takes the port in the same cycle, so no grant is offered.
  assign w_arb_en   = (r_state == RUN) && !scrub_start && !reset;
  assign req_ready  = w_arb_en ? w_grant : '0;
  assign w_xfer     = w_arb_en && w_any;
  assign w_sel_addr = req_addr[w_grant_idx*REG_ADDR_W +: REG_ADDR_W];
  assign w_sel_data = req_data[w_grant_idx*REG_DATA_W +: REG_DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:   if (scrub_start) w_next_state = SCRUB;
      SCRUB: if (r_counter == SCRUB_LAST) w_next_state = RUN;
      default: w_next_state = RUN;
    endcase
  end

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = r_write_register;
    w_wr_data = r_write_data;
    w_set_err = 1'b0;
    case (r_state)
      RUN: begin
        if (w_xfer) begin
          if (w_sel_addr != '0) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_sel_addr;
            w_wr_data = w_sel_data;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      SCRUB: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_counter;
        w_wr_data = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_counter        <= '0;
      r_last_grant     <= PW'(NUM_REQ - 1);
      r_write_switch   <= 1'b0;
      r_write_register <= '0;
      r_write_data     <= '0;
      r_busy           <= 1'b0;
      r_scrub_done     <= 1'b0;
      r_zero_err       <= 1'b0;
    end else begin
      r_write_switch   <= w_wr_en;
      r_write_register <= w_wr_addr;
      r_write_data     <= w_wr_data;
      // busy tracks the registered scrub writes; done fires as the last one retires
      r_busy           <= (r_state == SCRUB);
      r_scrub_done     <= r_busy && (r_state != SCRUB);
      if (w_xfer) r_last_grant <= w_grant_idx;
      if (w_set_err) begin
        r_zero_err <= 1'b1;
      end else if (err_clear) begin
        r_zero_err <= 1'b0;
      end
      if ((r_state == RUN) && scrub_start) begin
        r_counter <= SCRUB_FIRST;
      end else if (r_state == SCRUB) begin
        r_counter <= (r_counter == SCRUB_LAST) ? '0 : r_counter + 1'b1;
      end
    end
  end

  assign write_switch   = r_write_switch;
  assign write_register = r_write_register;
  assign write_data     = r_write_data;
  assign busy           = r_busy;
  assign scrub_done     = r_scrub_done;
  assign zero_write_err = r_zero_err;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: expected register-file writes are
// queued at issue time and a negedge monitor pops them as writes appear.
module tb_regfile_write_arbiter;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;
  logic            scrub_start;
  logic            err_clear;
  logic            write_switch;
  logic [4:0]      write_register;
  logic [31:0]     write_data;
  logic            busy;
  logic            scrub_done;
  logic            zero_write_err;

  int checks   = 0;
  int failures = 0;
  logic [36:0] exp_q[$];

  regfile_write_arbiter #(.NUM_REQ(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .scrub_start    (scrub_start),
    .err_clear      (err_clear),
    .write_switch   (write_switch),
    .write_register (write_register),
    .write_data     (write_data),
    .busy           (busy),
    .scrub_done     (scrub_done),
    .zero_write_err (zero_write_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = '0;
    scrub_start = 1'b0;
    err_clear   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Monitor: every presented write must match the oldest queued expectation.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (!reset && write_switch) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0d:%h required=none t=%0t",
                   write_register, write_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write", 64'({write_register, write_data}), 64'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    scrub_start = 1'b0;
    err_clear   = 1'b0;
    tick();
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_ws", 64'(write_switch), 64'(0));
    chk("rst_wreg", 64'(write_register), 64'(0));
    chk("rst_wdata", 64'(write_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(scrub_done), 64'(0));
    chk("rst_err", 64'(zero_write_err), 64'(0));
    tick();
    reset = 1'b0;

    // Single write from requester 0
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    settle();
    chk("t1_ready", 64'(req_ready), 64'(3'b001));
    push(5'd5, 32'hDEADBEEF);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    tick();

    // Fairness from a fresh pointer: 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      settle();
      chk("rr_ready", 64'(req_ready), 64'(3'b001 << (c % 3)));
      push(5'((c % 3) + 1), 32'h100 + 32'(c % 3));
      tick();
    end
    req_valid = '0;
    tick();

    // Register-0 write: accepted, not forwarded, sticky error
    do_reset();
    set_req(1, 1'b1, 5'd0, 32'h55);
    settle();
    chk("z_ready", 64'(req_ready), 64'(3'b010));
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("z_err_set", 64'(zero_write_err), 64'(1));
    tick();
    chk("z_err_hold", 64'(zero_write_err), 64'(1));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("z_err_clr", 64'(zero_write_err), 64'(0));
    set_req(1, 1'b1, 5'd0, 32'h66);
    err_clear = 1'b1;
    settle();
    chk("z_prio_ready", 64'(req_ready), 64'(3'b010));
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    err_clear = 1'b0;
    chk("z_set_prio", 64'(zero_write_err), 64'(1));
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("z_err_clr2", 64'(zero_write_err), 64'(0));

    // Scrub with requesters 0 and 2 pending (last_grant = 1)
    set_req(0, 1'b1, 5'd7, 32'hA0);
    set_req(2, 1'b1, 5'd9, 32'hA2);
    scrub_start = 1'b1;
    settle();
    chk("s_ready_start", 64'(req_ready), 64'(0));
    for (int a = 1; a <= 31; a++) push(5'(a), 32'h0);
    tick();
    scrub_start = 1'b0;
    chk("s_busy_pre", 64'(busy), 64'(0));
    for (int j = 1; j <= 31; j++) begin
      chk("s_ready", 64'(req_ready), 64'(0));
      tick();
      chk("s_busy", 64'(busy), 64'(1));
      chk("s_done_lo", 64'(scrub_done), 64'(0));
    end
    chk("s_ready_after", 64'(req_ready), 64'(3'b100));
    push(5'd9, 32'hA2);
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    settle();
    chk("s_done", 64'(scrub_done), 64'(1));
    chk("s_busy_end", 64'(busy), 64'(0));
    chk("s_ready_next", 64'(req_ready), 64'(3'b001));
    push(5'd7, 32'hA0);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk("s_done_pulse", 64'(scrub_done), 64'(0));

    // Reset at scrub address 10
    set_req(0, 1'b1, 5'd0, 32'h0);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    chk("r_err_pre", 64'(zero_write_err), 64'(1));
    set_req(0, 1'b1, 5'd12, 32'hC);
    scrub_start = 1'b1;
    for (int a = 1; a <= 10; a++) push(5'(a), 32'h0);
    tick();
    scrub_start = 1'b0;
    for (int j = 1; j <= 10; j++) tick();
    chk("r_addr10", 64'(write_register), 64'(10));
    #5;
    reset = 1'b1;
    #1;
    chk("r_ws", 64'(write_switch), 64'(0));
    chk("r_wreg", 64'(write_register), 64'(0));
    chk("r_wdata", 64'(write_data), 64'(0));
    chk("r_busy", 64'(busy), 64'(0));
    chk("r_done", 64'(scrub_done), 64'(0));
    chk("r_err", 64'(zero_write_err), 64'(0));
    chk("r_ready", 64'(req_ready), 64'(0));
    tick();
    reset = 1'b0;
    set_req(1, 1'b1, 5'd13, 32'hD);
    settle();
    chk("r_first", 64'(req_ready), 64'(3'b001));
    push(5'd12, 32'hC);
    tick();
    set_req(0, 1'b0, 5'd0, 32'h0);
    settle();
    chk("r_second", 64'(req_ready), 64'(3'b010));
    push(5'd13, 32'hD);
    tick();
    set_req(1, 1'b0, 5'd0, 32'h0);
    chk("r_no_scrub", 64'(busy), 64'(0));
    tick();
    chk("r_no_scrub2", 64'(busy), 64'(0));

    // Scrub with ignored restart/err_clear and a held register-0 request
    set_req(2, 1'b1, 5'd0, 32'hE);
    scrub_start = 1'b1;
    settle();
    chk("e_ready_start", 64'(req_ready), 64'(0));
    for (int a = 1; a <= 31; a++) push(5'(a), 32'h0);
    tick();
    scrub_start = 1'b0;
    for (int j = 1; j <= 31; j++) begin
      chk("e_ready", 64'(req_ready), 64'(0));
      chk("e_err_lo", 64'(zero_write_err), 64'(0));
      if (j == 5) begin
        scrub_start = 1'b1;
        err_clear   = 1'b1;
      end
      tick();
      scrub_start = 1'b0;
      err_clear   = 1'b0;
      chk("e_busy", 64'(busy), 64'(1));
    end
    chk("e_ready_after", 64'(req_ready), 64'(3'b100));
    tick();
    set_req(2, 1'b0, 5'd0, 32'h0);
    chk("e_err_set", 64'(zero_write_err), 64'(1));
    chk("e_done", 64'(scrub_done), 64'(1));
    tick();
    chk("e_busy_end", 64'(busy), 64'(0));
    chk("e_done_pulse", 64'(scrub_done), 64'(0));
    tick();
    chk("e_busy_end2", 64'(busy), 64'(0));

    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file among `NUM_REQ` writeback requesters (ALU, load unit, debug port, ...) using round-robin arbitration with a valid/ready handshake. It also sequences a scrub that zeroes registers 1..31 on request. Writes to register 0 are filtered and flagged before they reach the file. The block sits between the writeback sources and the register file's `write_switch` / `write_register` / `write_data` inputs.

## Interface
- `NUM_REQ`, default 3: number of requesters; legal range 2..8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_addr`  in  NUM_REQ*5  flattened target register; requester i uses bits [5i+4:5i].
- `req_data`  in  NUM_REQ*32  flattened write data; requester i uses bits [32i+31:32i].
- `scrub_start`  in  1  one-cycle pulse that starts the zeroing sequence.
- `err_clear`  in  1  clears `zero_write_err`.
- `write_switch`  out  1  register file write enable (registered).
- `write_register`  out  5  register file write address (registered).
- `write_data`  out  32  register file write data (registered).
- `busy`  out  1  high while in SCRUB.
- `scrub_done`  out  1  one-cycle pulse when the scrub completes.
- `zero_write_err`  out  1  sticky flag: a requester targeted register 0.

## Operation
- FSM has two states, RUN and SCRUB. Reset state is RUN.
- RUN:
  - The arbiter grants the first valid requester found searching from `(last_grant+1) mod NUM_REQ` upward.
  - `req_ready` = grant one-hot. It is combinational from `req_valid` and the pointer.
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - `last_grant` updates only on a transfer.
- Transfer with address != 0: the next cycle drives `write_switch`=1, `write_register`=addr, `write_data`=data.
- Transfer with address 0:
  - It is accepted (ready asserted) but not forwarded; `write_switch`=0 next cycle.
  - `zero_write_err` is set. The pointer still advances.
- No transfer: `write_switch`=0 next cycle. `write_register`/`write_data` hold their last values.
- `scrub_start` in RUN:
  - All `req_ready` drop to 0 in that same cycle.
  - The FSM enters SCRUB with counter=1.
- SCRUB:
  - Each cycle drives `write_switch`=1, `write_register`=counter, `write_data`=0, then increments the counter.
  - After address 31 is issued, the FSM returns to RUN and pulses `scrub_done` for 1 cycle.
  - `req_ready`=0 throughout SCRUB; requesters must hold valid/addr/data.
  - `scrub_start` during SCRUB is ignored.
- `zero_write_err`:
  - Set has priority over `err_clear` in the same cycle.
  - Cleared only by `err_clear` or `reset`.
- Reset (asserted at any time, including mid-scrub):
  - State=RUN, counter=0, `last_grant`=NUM_REQ-1 (requester 0 wins first).
  - All outputs 0: `req_ready`, `write_switch`, `write_register`, `write_data`, `busy`, `scrub_done`, `zero_write_err`.
  - An interrupted scrub is not resumed.

## Timing
- Accept-to-write latency: 1 cycle. Outputs are registered at posedge and stable before the register file's negedge write.
- Throughput: one write per cycle in RUN.
- Scrub:
  - `scrub_start` sampled at edge k.
  - `write_switch` high for edges k+1..k+31, addresses 1..31.
  - `busy` high for the same 31 cycles.
  - `scrub_done` high during the cycle after address 31 is presented; `req_ready` may reassert in that cycle.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Simultaneous `scrub_start` and valid requests in RUN: the scrub wins and no transfer occurs that cycle.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W`=5, `REG_DATA_W`=32, `NUM_REGS`=32.
  - `SCRUB_FIRST`=1, `SCRUB_LAST`=31.
  - Enum `wr_arb_state_t` {RUN, SCRUB}.
- Sub-module `rr_arbiter`:
  - Parameterised by `NUM_REQ`; combinational grant from request vector and `last_grant`.
  - The pointer register lives in the parent so it updates only on a transfer.

## Test plan
- Reset, then requester 0 valid with addr 5, data 0xDEADBEEF → `req_ready`=3'b001 same cycle; next cycle `write_switch`=1, `write_register`=5, `write_data`=0xDEADBEEF.
- NUM_REQ=3, all valid with addrs 1, 2, 3 for 6 cycles → grant order 0, 1, 2, 0, 1, 2; write addresses 1, 2, 3, 1, 2, 3.
- Requester 1 alone with addr 0 → accepted, `write_switch` stays 0, `zero_write_err`=1 and holds; `err_clear` pulse → 0.
- `scrub_start` while requesters 0 and 2 are valid:
  - `req_ready`=0 for 31 cycles while addresses 1..31 are written with data 0.
  - `scrub_done` pulses once.
  - Next grant goes to the requester after `last_grant`.
- `reset` asserted at scrub address 10 → all outputs 0 immediately (asynchronous), `busy`=0; after release, requester 0 is granted first and no scrub writes occur.
- `scrub_start` and `err_clear` pulsed during SCRUB while a pending addr-0 request is held → scrub length stays 31 cycles, `zero_write_err` stays 0 until the addr-0 request is accepted after the scrub.
